// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data side has fixed priority, and instruction
// fetch is guaranteed a grant after MAX_WAIT cycles of waiting.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_byteenable,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_waitrequest,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic                    m_rd,
  output logic                    m_wr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_waitrequest,
  output logic                    grant_i,
  output logic                    grant_d
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_next;
  logic          d_req;
  logic          i_done;
  logic          d_done;

  function automatic state_t arb(input logic [CW-1:0] w, input logic ird, input logic dreq);
    state_t r;
    if (ird && (w >= CW'(MAX_WAIT)))
      r = GRANT_I;
    else if (dreq)
      r = GRANT_D;
    else if (ird)
      r = GRANT_I;
    else
      r = IDLE;
    return r;
  endfunction

  assign d_req  = d_rd | d_wr;
  assign i_done = (state == GRANT_I) && i_rd && !m_waitrequest;
  assign d_done = (state == GRANT_D) && d_req && !m_waitrequest;

  // Starvation counter: counts cycles fetch has been asking without completing.
  always_comb begin
    wcnt_next = wcnt;
    if (i_done || !i_rd)
      wcnt_next = '0;
    else if (wcnt < CW'(MAX_WAIT))
      wcnt_next = wcnt + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      wcnt <= wcnt_next;
      case (state)
        IDLE: state <= arb(wcnt, i_rd, d_req);
        GRANT_I: begin
          if (!i_rd)
            state <= IDLE;
          else if (i_done)
            state <= arb(wcnt_next, i_rd, d_req);
        end
        GRANT_D: begin
          if (!d_req)
            state <= IDLE;
          else if (d_done)
            state <= arb(wcnt_next, i_rd, d_req);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_i = (state == GRANT_I);
  assign grant_d = (state == GRANT_D);

  // The granted requester's signals pass straight through so an abort drops m_rd/m_wr at once.
  always_comb begin
    m_addr       = '0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    m_wdata      = '0;
    m_byteenable = '0;
    case (state)
      GRANT_I: begin
        m_addr       = i_addr;
        m_rd         = i_rd;
        m_byteenable = {BE_WIDTH{1'b1}};
      end
      GRANT_D: begin
        m_addr       = d_addr;
        m_rd         = d_rd;
        m_wr         = d_wr;
        m_wdata      = d_wdata;
        m_byteenable = d_byteenable;
      end
      default: ;
    endcase
  end

  assign i_waitrequest = !i_done;
  assign d_waitrequest = !d_done;
  assign i_rdata       = m_rdata;
  assign d_rdata       = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural owner/wait-count model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr;
  logic          i_rd;
  logic [DW-1:0] i_rdata;
  logic          i_waitrequest;
  logic [AW-1:0] d_addr;
  logic          d_rd;
  logic          d_wr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_byteenable;
  logic [DW-1:0] d_rdata;
  logic          d_waitrequest;
  logic [AW-1:0] m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_byteenable;
  logic [DW-1:0] m_rdata;
  logic          m_waitrequest;
  logic          grant_i;
  logic          grant_d;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the port (0 nobody, 1 fetch, 2 data) and how long fetch has waited.
  int owner  = 0;
  int waited = 0;
  bit saw_i_complete;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata), .i_waitrequest(i_waitrequest),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_waitrequest(d_waitrequest),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_byteenable(m_byteenable), .m_rdata(m_rdata), .m_waitrequest(m_waitrequest),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int pick(input int w, input bit ird, input bit dreq);
    if (ird && w >= MW) return 1;
    if (dreq) return 2;
    if (ird) return 1;
    return 0;
  endfunction

  // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model across the edge.
  task automatic applyStimulus(input bit rst, input bit ird, input logic [AW-1:0] iaddr,
                               input bit drd, input bit dwr, input logic [AW-1:0] daddr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                               input bit mwait, input logic [DW-1:0] rdata);
    bit            dreq, idone, ddone;
    int            wn;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    bit            e_rd, e_wr;
    reset = rst; i_rd = ird; i_addr = iaddr; d_rd = drd; d_wr = dwr; d_addr = daddr;
    d_wdata = wdata; d_byteenable = be; m_waitrequest = mwait; m_rdata = rdata;
    #3;
    dreq  = drd || dwr;
    idone = (owner == 1) && ird && !mwait;
    ddone = (owner == 2) && dreq && !mwait;
    e_addr = '0; e_rd = 0; e_wr = 0; e_wdata = '0; e_be = '0;
    if (owner == 1) begin
      e_addr = iaddr; e_rd = ird; e_be = '1;
    end else if (owner == 2) begin
      e_addr = daddr; e_rd = drd; e_wr = dwr; e_wdata = wdata; e_be = be;
    end
    checkOutput("m_addr", DW'(m_addr), DW'(e_addr));
    checkOutput("m_rd", DW'(m_rd), DW'(e_rd));
    checkOutput("m_wr", DW'(m_wr), DW'(e_wr));
    checkOutput("m_wdata", m_wdata, e_wdata);
    checkOutput("m_byteenable", DW'(m_byteenable), DW'(e_be));
    checkOutput("i_waitrequest", DW'(i_waitrequest), DW'(!idone));
    checkOutput("d_waitrequest", DW'(d_waitrequest), DW'(!ddone));
    checkOutput("grant_i", DW'(grant_i), DW'(owner == 1));
    checkOutput("grant_d", DW'(grant_d), DW'(owner == 2));
    checkOutput("i_rdata", i_rdata, rdata);
    checkOutput("d_rdata", d_rdata, rdata);
    saw_i_complete = (i_waitrequest === 1'b0);
    wn = (idone || !ird) ? 0 : ((waited + 1 > MW) ? MW : waited + 1);
    if (rst) begin
      owner = 0; wn = 0;
    end else if (owner == 0) begin
      owner = pick(waited, ird, dreq);
    end else if (owner == 1) begin
      if (!ird) owner = 0;
      else if (idone) owner = pick(wn, ird, dreq);
    end else begin
      if (!dreq) owner = 0;
      else if (ddone) owner = pick(wn, ird, dreq);
    end
    waited = wn;
    @(posedge clock);
    #1;
  endtask

  task automatic resetCycle();
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0, 1, '0);
  endtask

  initial begin
    int  last_i;
    int  n_i;
    bit  ird_r;
    int  k;
    $display("[TB] mem_arbiter bench start");
    reset = 1; i_rd = 1; d_rd = 1; d_wr = 0; i_addr = '0; d_addr = '0;
    d_wdata = '0; d_byteenable = '0; m_waitrequest = 1; m_rdata = '0;
    @(posedge clock);
    #1;
    owner = 0; waited = 0;

    // Reset held with both requesting; data wins one cycle after release.
    applyStimulus(1, 1, 32'h100, 1, 0, 32'h200, '0, '0, 1, 128'h1);
    applyStimulus(0, 1, 32'h100, 1, 0, 32'h200, '0, '0, 1, 128'h2);
    checkOutput("s1_grant_d", DW'(grant_d), DW'(1));

    // Back-to-back fetch reads with a moving address.
    resetCycle();
    for (int a = 0; a < 4; a++)
      applyStimulus(0, 1, AW'(a * 16), 0, 0, '0, '0, '0, 0, DW'(a));

    // Both requesting continuously: fetch must complete every fifth transfer.
    resetCycle();
    last_i = -1; n_i = 0;
    for (int c = 0; c < 32; c++) begin
      applyStimulus(0, 1, AW'(32'h40 + c), 1, 0, AW'(32'h80 + c), '0, '0, 0, DW'(c));
      if (saw_i_complete) begin
        if (last_i >= 0) checkOutput("s3_i_gap", DW'(c - last_i), DW'(5));
        last_i = c; n_i++;
      end
    end
    checkOutput("s3_i_count", DW'(n_i >= 5), DW'(1));

    // Data write stalled three cycles while fetch waits.
    resetCycle();
    for (int c = 0; c < 5; c++)
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h400, {4{32'hA5A5_0000 + 32'(c)}}, 16'h0F3C,
                    (c < 4), 128'h55);
    applyStimulus(0, 0, 32'h300, 0, 0, 32'h400, '0, '0, 0, 128'h56);

    // Fetch abort while stalled, then data takes over.
    resetCycle();
    applyStimulus(0, 1, 32'h500, 0, 0, '0, '0, '0, 1, '0);
    applyStimulus(0, 1, 32'h500, 0, 0, '0, '0, '0, 1, '0);
    applyStimulus(0, 0, 32'h500, 1, 0, 32'h600, '0, '0, 1, '0);
    applyStimulus(0, 0, 32'h500, 1, 0, 32'h600, '0, '0, 1, '0);
    checkOutput("s5_grant_d", DW'(grant_d), DW'(1));
    applyStimulus(0, 0, 32'h500, 1, 0, 32'h600, '0, '0, 0, 128'h77);

    // Reset in the middle of a stalled data write.
    resetCycle();
    applyStimulus(0, 0, '0, 0, 1, 32'h700, 128'hBEEF, 16'hFFFF, 1, '0);
    applyStimulus(0, 0, '0, 0, 1, 32'h700, 128'hBEEF, 16'hFFFF, 1, '0);
    applyStimulus(1, 0, '0, 0, 1, 32'h700, 128'hBEEF, 16'hFFFF, 1, '0);
    applyStimulus(0, 0, '0, 0, 1, 32'h700, 128'hBEEF, 16'hFFFF, 1, '0);

    // Random traffic; fetch requests are sticky like a real fetch unit.
    ird_r = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) ird_r = !ird_r;
      k = $urandom_range(0, 3);
      applyStimulus(($urandom_range(0, 99) == 0), ird_r, $urandom, (k == 1), (k == 2), $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, BW'($urandom),
                    bit'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
